multi_camera_stream_mux: RTL

//  Next-generation capture front end for NUM_CAMS OV7670-class cameras, all handled in one system clock.
//  - Per camera: oversample pclk/vsync/href/data, pair bytes into RGB565, track pixel x/y.
//  - Per camera: buffer pixels in a small FIFO.
//  - Merge all cameras round-robin into one valid/ready stream tagged with camera id and coordinates.
//  - Sits between the camera pins and the BEV warp/frame-buffer writer.

---
 rtl/multi_camera_stream_mux.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_camera_stream_mux.sv
// Capture front end for NUM_CAMS byte-wide cameras: oversampled inputs, per-camera
// RGB565 assembly into small FIFOs, round-robin merge onto one tagged valid/ready stream.
module multi_camera_stream_mux #(
  parameter  int NUM_CAMS    = 4,
  parameter  int IMG_WIDTH   = 640,
  parameter  int IMG_HEIGHT  = 480,
  parameter  int FIFO_DEPTH  = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int CAM_W       = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CAMS-1:0]   pclk,
  input  logic [NUM_CAMS-1:0]   vsync,
  input  logic [NUM_CAMS-1:0]   href,
  input  logic [NUM_CAMS*8-1:0] data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CAM_W-1:0]      m_cam,
  output logic [9:0]            m_x,
  output logic [8:0]            m_y,
  output logic [15:0]           m_pixel,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic [NUM_CAMS-1:0]   frame_done,
  output logic [NUM_CAMS-1:0]   overflow,
  input  logic [NUM_CAMS-1:0]   ovf_clr
);
  // Capture FSM, one per camera
  //   state      | meaning
  //   WAIT_FRAME | idle until the synced vsync falls
  //   ACTIVE     | pairing bytes into pixels, tracking x/y

  localparam int                PW       = $clog2(FIFO_DEPTH);
  localparam logic [10:0]       X_LIM    = 11'(IMG_WIDTH);
  localparam logic [9:0]        Y_LIM    = 10'(IMG_HEIGHT);
  localparam logic [9:0]        X_LAST   = 10'(IMG_WIDTH - 1);
  localparam logic [CAM_W:0]    NCAM     = (CAM_W+1)'(NUM_CAMS);
  localparam logic [CAM_W-1:0]  LAST_CAM = CAM_W'(NUM_CAMS - 1);
  localparam logic [CAM_W-1:0]  CAM_ONE  = CAM_W'(1);
  localparam logic [PW:0]       PTR_ONE  = (PW+1)'(1);

  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} cap_state_t;
  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] pix;
  } beat_t;

  beat_t               head [NUM_CAMS];
  logic [NUM_CAMS-1:0] empty;
  logic [NUM_CAMS-1:0] pop;
  logic [CAM_W-1:0]    rr_q;
  logic [CAM_W-1:0]    grant;
  logic [CAM_W-1:0]    arb_idx;
  logic [CAM_W:0]      arb_sum;
  logic                any;
  logic                load;

  for (genvar c = 0; c < NUM_CAMS; c++) begin : g_cam
    logic [10:0] sync_q [SYNC_STAGES];
    logic        s_pclk, s_vsync, s_href;
    logic [7:0]  s_data;
    logic        pclk_q, vsync_q;
    logic        ev, v_rise, v_fall;

    cap_state_t  state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        tog_q, tog_d;
    logic [7:0]  hi_q, hi_d;
    logic        href_q, href_d;
    logic        done_q, done_d;
    logic        push_c;
    beat_t       push_beat;

    beat_t       mem [FIFO_DEPTH];
    logic [PW:0] wr_q, rd_q;
    logic        full_c, wr_en;
    logic        ovf_q;

    // pclk, vsync, href and data travel together so they stay cycle-aligned
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= {pclk[c], vsync[c], href[c], data[8*c +: 8]};
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign {s_pclk, s_vsync, s_href, s_data} = sync_q[SYNC_STAGES-1];
    assign ev     = s_pclk & ~pclk_q;
    assign v_rise = s_vsync & ~vsync_q;
    assign v_fall = ~s_vsync & vsync_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= WAIT_FRAME;
        x_q     <= '0;
        y_q     <= '0;
        tog_q   <= 1'b0;
        hi_q    <= '0;
        href_q  <= 1'b0;
        done_q  <= 1'b0;
        pclk_q  <= 1'b0;
        vsync_q <= 1'b0;
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        tog_q   <= tog_d;
        hi_q    <= hi_d;
        href_q  <= href_d;
        done_q  <= done_d;
        pclk_q  <= s_pclk;
        vsync_q <= s_vsync;
      end
    end

    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      tog_d   = tog_q;
      hi_d    = hi_q;
      href_d  = href_q;
      done_d  = 1'b0;
      push_c  = 1'b0;
      case (state_q)
        WAIT_FRAME: begin
          if (v_fall) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            tog_d   = 1'b0;
            href_d  = 1'b0;
          end
        end
        ACTIVE: begin
          if (v_rise) begin
            state_d = WAIT_FRAME;
            done_d  = (y_q != 9'd0);
          end else if (ev) begin
            href_d = s_href;
            if (s_href) begin
              if (!tog_q) begin
                hi_d  = s_data;
                tog_d = 1'b1;
              end else begin
                tog_d  = 1'b0;
                push_c = ({1'b0, x_q} < X_LIM) && ({1'b0, y_q} < Y_LIM);
                if (x_q != 10'h3FF) x_d = x_q + 10'd1;
              end
            end else if (href_q) begin
              // line end; a pending odd byte is simply forgotten
              x_d   = '0;
              tog_d = 1'b0;
              if (y_q != 9'h1FF) y_d = y_q + 9'd1;
            end
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end

    assign push_beat = '{x: x_q, y: y_q, pix: {hi_q, s_data}};
    assign full_c    = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en     = push_c && (!full_c || pop[c]);

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q[PW-1:0]] <= push_beat;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (wr_en)  wr_q <= wr_q + PTR_ONE;
        if (pop[c]) rd_q <= rd_q + PTR_ONE;
        ovf_q <= (push_c && full_c && !pop[c]) || (ovf_q && !ovf_clr[c]);
      end
    end

    assign empty[c]      = (wr_q == rd_q);
    assign head[c]       = mem[rd_q[PW-1:0]];
    assign frame_done[c] = done_q;
    assign overflow[c]   = ovf_q;
  end

  // rr_q holds the camera the next search starts from
  always_comb begin
    any     = 1'b0;
    grant   = rr_q;
    arb_sum = '0;
    arb_idx = '0;
    for (int k = 0; k < NUM_CAMS; k++) begin
      arb_sum = {1'b0, rr_q} + (CAM_W+1)'(k);
      if (arb_sum >= NCAM) arb_sum = arb_sum - NCAM;
      arb_idx = arb_sum[CAM_W-1:0];
      if (!any && !empty[arb_idx]) begin
        any   = 1'b1;
        grant = arb_idx;
      end
    end
  end

  assign load = !m_valid || m_ready;

  always_comb begin
    pop = '0;
    if (load && any) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_cam   <= '0;
      m_x     <= '0;
      m_y     <= '0;
      m_pixel <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      rr_q    <= '0;
    end else if (load) begin
      m_valid <= any;
      if (any) begin
        m_cam   <= grant;
        m_x     <= head[grant].x;
        m_y     <= head[grant].y;
        m_pixel <= head[grant].pix;
        m_sof   <= (head[grant].x == 10'd0) && (head[grant].y == 9'd0);
        m_eol   <= (head[grant].x == X_LAST);
        rr_q    <= (grant == LAST_CAM) ? '0 : grant + CAM_ONE;
      end
    end
  end

endmodule
